desc_wb_slave: RTL

- Wishbone slave descriptor memory: the responder end of the DMA controller's 64-bit descriptor/control bus (32-bit dat plus dat64 high word, ack/rty/err, cab bursts).
- Serves descriptor fetch bursts (reads) and control write-back bursts (writes) from an on-chip 2^AW x 64-bit RAM.
- A side host port preloads and inspects descriptors.
- Used as the descriptor store in the DMA subsystem and as the bus partner in the controller test bench.

---
 rtl/desc_wb_slave.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/desc_wb_slave.sv
// rtl/desc_wb_slave.sv - Wishbone slave descriptor RAM with host side port
module desc_wb_slave #(
  parameter logic [28:0] BASE     = 29'h0000000,
  parameter int          AW       = 4,
  parameter int          WAIT_CYC = 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic          wbs_cab_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  input  logic [31:0]   wbs_dat64_i,
  output logic [31:0]   wbs_dat_o,
  output logic [31:0]   wbs_dat64_o,
  output logic          wbs_ack_o,
  output logic          wbs_err_o,
  output logic          wbs_rty_o,
  input  logic          lock,
  input  logic          host_we,
  input  logic [AW-1:0] host_adr,
  input  logic [63:0]   host_dat,
  output logic [63:0]   host_rdat,
  output logic [2:0]    slv_state
);

  localparam int          DEPTH     = 1 << AW;
  localparam logic [28:0] DEPTH_W   = 29'(DEPTH);
  localparam logic [2:0]  WAIT_LAST = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_ACK  = 3'd2;
  localparam logic [2:0] S_ERR  = 3'd3;
  localparam logic [2:0] S_RTY  = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  logic [63:0]   ram [DEPTH];

  logic [2:0]    state, state_n;
  logic [2:0]    wcnt, wcnt_n;
  logic [AW-1:0] idx, idx_n;
  logic [AW-1:0] beat, beat_n;
  logic          we_q, we_n;
  logic          cab_q, cab_n;

  logic          req;
  logic [28:0]   win_off;
  logic          in_range;
  logic [AW-1:0] beat_addr;
  logic [AW-1:0] rd_addr;
  logic          wb_wr;
  logic          host_wr;
  logic [63:0]   wr_word;
  logic [63:0]   rd_word;
  logic [63:0]   dat_q;
  logic          unused_adr_lsb;

  // The low three address bits select a byte inside the 64-bit entry and carry no meaning here.
  assign unused_adr_lsb = ^wbs_adr_i[2:0];

  assign req       = wbs_cyc_i & wbs_stb_i;
  assign win_off   = wbs_adr_i[31:3] - BASE;
  assign in_range  = win_off < DEPTH_W;
  assign beat_addr = idx + beat;

  // Beat handshake: the ack phase is a registered state, qualified by the live strobe so a paused
  // or aborted master never sees an ack.
  assign wbs_ack_o = (state == S_ACK) & req;
  assign wbs_err_o = (state == S_ERR) & wbs_cyc_i;
  assign wbs_rty_o = (state == S_RTY) & wbs_cyc_i;
  assign slv_state = state;

  assign wb_wr   = wbs_ack_o & we_q;
  // A bus write to the same entry in the same cycle takes precedence over the host.
  assign host_wr = host_we & ~(wb_wr & (beat_addr == host_adr));

  assign wbs_dat_o   = dat_q[31:0];
  assign wbs_dat64_o = dat_q[63:32];

  // Next-state logic for the request/wait/ack/hold sequencer and its beat bookkeeping.
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    idx_n   = idx;
    beat_n  = beat;
    we_n    = we_q;
    cab_n   = cab_q;
    case (state)
      S_IDLE: begin
        if (req) begin
          idx_n  = wbs_adr_i[AW+2:3];
          we_n   = wbs_we_i;
          cab_n  = wbs_cab_i;
          beat_n = '0;
          wcnt_n = 3'd0;
          if (!in_range) begin
            state_n = S_ERR;
          end else if (lock) begin
            state_n = S_RTY;
          end else if (WAIT_CYC == 0) begin
            state_n = S_ACK;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i) begin
          state_n = S_IDLE;
        end else if (wcnt == WAIT_LAST) begin
          state_n = S_ACK;
        end else begin
          wcnt_n = wcnt + 3'd1;
        end
      end
      S_ACK: begin
        if (!wbs_cyc_i) begin
          state_n = S_IDLE;
        end else if (wbs_ack_o) begin
          beat_n = beat + 1'b1;
          if (!cab_q) begin
            state_n = S_HOLD;
          end
        end
      end
      S_ERR, S_RTY: begin
        state_n = wbs_cyc_i ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!req) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Merge the byte-enabled bus write into the current entry; sel covers both 32-bit halves.
  always_comb begin
    wr_word = ram[beat_addr];
    for (int b = 0; b < 4; b++) begin
      if (wbs_sel_i[b]) begin
        wr_word[8*b +: 8]      = wbs_dat_i[8*b +: 8];
        wr_word[32 + 8*b +: 8] = wbs_dat64_i[8*b +: 8];
      end
    end
  end

  // Fetch the entry for the beat presented next cycle, forwarding any write landing this edge.
  assign rd_addr = idx_n + beat_n;
  always_comb begin
    rd_word = ram[rd_addr];
    if (host_wr && (host_adr == rd_addr)) begin
      rd_word = host_dat;
    end
    if (wb_wr && (beat_addr == rd_addr)) begin
      rd_word = wr_word;
    end
  end

  // Sequencer state, latched request fields and registered read data.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      wcnt  <= 3'd0;
      idx   <= '0;
      beat  <= '0;
      we_q  <= 1'b0;
      cab_q <= 1'b0;
      dat_q <= 64'd0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      idx   <= idx_n;
      beat  <= beat_n;
      we_q  <= we_n;
      cab_q <= cab_n;
      dat_q <= rd_word;
    end
  end

  // Descriptor storage; contents survive reset so preloaded descriptors are kept.
  always_ff @(posedge wb_clk_i) begin
    if (host_wr) begin
      ram[host_adr] <= host_dat;
    end
    if (wb_wr) begin
      ram[beat_addr] <= wr_word;
    end
  end

  // Host readback shows the entry as it was before any write on the same edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      host_rdat <= 64'd0;
    end else begin
      host_rdat <= ram[host_adr];
    end
  end

endmodule
